// File: rtl/sram_controller_pkg.sv
// Shared types and default geometry for the memory-stage SRAM controller.
package sram_controller_pkg;

  localparam int unsigned SRAM_BASE_ADDR  = 1024;
  localparam int unsigned SRAM_ADDR_WIDTH = 18;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

  // 32-bit word index of a byte address relative to the SRAM base.
  function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Memory-stage load/store responder: each 32-bit access is split into two 16-bit SRAM phases.
// Optional SRAM_ADDR_RANGE_CHECK_EN adds addrError and skips out-of-range requests.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = SRAM_BASE_ADDR,
  parameter int unsigned SRAM_ADDR_W   = SRAM_ADDR_WIDTH,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memReadEn,
  input  logic                   memWriteEn,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_ce_n,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ub_n,
`ifdef SRAM_ADDR_RANGE_CHECK_EN
  output logic                   addrError,
`endif
  output logic                   sram_lb_n
);

  localparam int unsigned WordW = SRAM_ADDR_W - 1;
  localparam int unsigned CntW  = 4;
  localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [WordW-1:0] word_q;
  logic            is_write_q;
  logic [15:0]     wdata_hi_q;

  logic             req;
  logic [WordW-1:0] word;

  assign req  = memReadEn | memWriteEn;
  assign word = WordW'(word_offset(address, 32'(BASE_ADDR)));

`ifdef SRAM_ADDR_RANGE_CHECK_EN
  logic range_err;
  assign range_err = (address < 32'(BASE_ADDR)) ||
                     (word_offset(address, 32'(BASE_ADDR)) >= (32'd1 << WordW));
`endif

  assign ready = ((state_q == StIdle) && !req) || (state_q == StDone);

  // SRAM pins are registered from the transition so they change in step with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      word_q      <= '0;
      is_write_q  <= 1'b0;
      wdata_hi_q  <= '0;
      readData    <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
`ifdef SRAM_ADDR_RANGE_CHECK_EN
      addrError   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            cnt_q      <= '0;
            word_q     <= word;
            is_write_q <= memWriteEn;
            wdata_hi_q <= writeData[31:16];
`ifdef SRAM_ADDR_RANGE_CHECK_EN
            if (range_err) begin
              state_q   <= StDone;
              addrError <= 1'b1;
            end else
`endif
            begin
              state_q     <= StLow;
              sram_addr   <= {word, 1'b0};
              sram_dq_out <= memWriteEn ? writeData[15:0] : 16'h0000;
              sram_dq_oe  <= memWriteEn;
              sram_ce_n   <= 1'b0;
              sram_we_n   <= ~memWriteEn;
              sram_oe_n   <= memWriteEn;
              sram_ub_n   <= 1'b0;
              sram_lb_n   <= 1'b0;
            end
          end
        end
        StLow: begin
          if (cnt_q == CntLast) begin
            cnt_q     <= '0;
            state_q   <= StHigh;
            sram_addr <= {word_q, 1'b1};
            if (is_write_q) sram_dq_out <= wdata_hi_q;
            else            readData[15:0] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHigh: begin
          if (cnt_q == CntLast) begin
            cnt_q       <= '0;
            state_q     <= StDone;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            if (!is_write_q) readData[31:16] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
`ifdef SRAM_ADDR_RANGE_CHECK_EN
          addrError <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a halfword SRAM model that commits full-length writes.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int unsigned AccessCycles = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReadEn, memWriteEn;
  logic [31:0] address, writeData, readData;
  logic        ready;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_ADDR_RANGE_CHECK_EN
  logic        addrError;
`endif

  sram_controller #(
    .BASE_ADDR    (SRAM_BASE_ADDR),
    .SRAM_ADDR_W  (SRAM_ADDR_WIDTH),
    .ACCESS_CYCLES(AccessCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memReadEn  (memReadEn),
    .memWriteEn (memWriteEn),
    .address    (address),
    .writeData  (writeData),
    .readData   (readData),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_ce_n  (sram_ce_n),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ub_n  (sram_ub_n),
`ifdef SRAM_ADDR_RANGE_CHECK_EN
    .addrError  (addrError),
`endif
    .sram_lb_n  (sram_lb_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [15:0] mem [0:63] = '{default: 16'h0000};
  logic [SRAM_ADDR_WIDTH-1:0] rd_log[$];
  int checks = 0;
  int errors = 0;
  int ce_low_cycles = 0;
  int we_run = 0;
  logic [SRAM_ADDR_WIDTH-1:0] we_addr = '0;

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'hA5A5;

  // A halfword is committed only after we_n has been held low for the full phase.
  always @(posedge clk) begin
    int nxt;
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      nxt = (we_run > 0 && sram_addr == we_addr) ? we_run + 1 : 1;
      if (nxt == AccessCycles) mem[sram_addr[5:0]] <= sram_dq_out;
      we_run  <= nxt;
      we_addr <= sram_addr;
    end else begin
      we_run <= 0;
    end
  end

  // Monitor: pin activity log plus scoreboard pop on each completed transaction.
  always @(negedge clk) begin
    if (!sram_ce_n) ce_low_cycles <= ce_low_cycles + 1;
    if (!sram_ce_n && !sram_oe_n) rd_log.push_back(sram_addr);
    if (!rst && ready && (memReadEn || memWriteEn)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected completion, readData=%h", readData);
      end else begin
        e = sb.pop_front();
`ifdef SRAM_ADDR_RANGE_CHECK_EN
        if (readData !== e.data || addrError !== e.err) begin
          errors++;
          $display("FAIL scoreboard: readData=%h addrError=%b expected %h / %b",
                   readData, addrError, e.data, e.err);
        end
`else
        if (readData !== e.data) begin
          errors++;
          $display("FAIL scoreboard: readData=%h expected %h", readData, e.data);
        end
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic [31:0] data, input logic err);
    exp_t x;
    x.data = data;
    x.err  = err;
    sb.push_back(x);
  endtask

  // Drives one request from just after a rising edge and waits for ready (bounded).
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int stall);
    memReadEn  = rd;
    memWriteEn = wr;
    address    = addr;
    writeData  = data;
    stall      = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) break;
      stall++;
    end
    if (!ready) begin
      errors++;
      $display("FAIL access_timeout: ready=%b after %0d cycles, required 1", ready, stall);
    end
    @(posedge clk);
    #1;
    memReadEn  = 1'b0;
    memWriteEn = 1'b0;
  endtask

  initial begin
    int st;
    int idx;
    int ce_before;
    logic [31:0] seq;
    rst = 1'b1;
    memReadEn = 1'b0;
    memWriteEn = 1'b0;
    address = '0;
    writeData = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_readdata", readData, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_pins", {25'h0, ready, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n,
                          sram_dq_oe}, {25'h0, 7'b1111110});
    end
    @(posedge clk);
    #1;

    expect_done(32'h0000_0000, 1'b0);
    access(1'b0, 1'b1, 32'h408, 32'hDEAD_BEEF, st);
    check("write_stall", st, 5);
    check("mem_hw4", {16'h0, mem[4]}, 32'h0000_BEEF);
    check("mem_hw5", {16'h0, mem[5]}, 32'h0000_DEAD);

    idx = rd_log.size();
    expect_done(32'hDEAD_BEEF, 1'b0);
    access(1'b1, 1'b0, 32'h408, 32'h0, st);
    check("read_stall", st, 5);
    if (rd_log.size() == idx + 4) begin
      seq = {rd_log[idx][7:0], rd_log[idx+1][7:0], rd_log[idx+2][7:0], rd_log[idx+3][7:0]};
      check("read_addr_seq", seq, 32'h0404_0505);
    end else begin
      check("read_oe_cycles", rd_log.size() - idx, 4);
    end

    // Back-to-back write then read, then a dual request that must act as a write.
    expect_done(32'hDEAD_BEEF, 1'b0);
    access(1'b0, 1'b1, 32'h40C, 32'h1122_3344, st);
    check("b2b_write_stall", st, 5);
    expect_done(32'h1122_3344, 1'b0);
    access(1'b1, 1'b0, 32'h40C, 32'h0, st);
    check("b2b_read_stall", st, 5);
    expect_done(32'h1122_3344, 1'b0);
    access(1'b1, 1'b1, 32'h410, 32'h5566_7788, st);
    check("dual_stall", st, 5);
    check("mem_hw8", {16'h0, mem[8]}, 32'h0000_7788);
    expect_done(32'h5566_7788, 1'b0);
    access(1'b1, 1'b0, 32'h410, 32'h0, st);

    // Reset during the second HIGH cycle of a write.
    memWriteEn = 1'b1;
    address    = 32'h414;
    writeData  = 32'h1234_5678;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_pins", {26'h0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe},
          {26'h0, 6'b111110});
    check("rst_readdata", readData, 32'h0);
    check("rst_ready_req", {31'h0, ready}, 32'h0);
    memWriteEn = 1'b0;
    #1;
    check("rst_ready_idle", {31'h0, ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    expect_done(32'h0000_5678, 1'b0);
    access(1'b1, 1'b0, 32'h414, 32'h0, st);
    check("aborted_hw11", {16'h0, mem[11]}, 32'h0);

`ifdef SRAM_ADDR_RANGE_CHECK_EN
    ce_before = ce_low_cycles;
    expect_done(32'h0000_5678, 1'b1);
    access(1'b1, 1'b0, 32'h3FC, 32'h0, st);
    check("range_stall", st, 1);
    check("range_no_strobe", ce_low_cycles - ce_before, 0);
`else
    ce_before = ce_low_cycles;
    check("ce_activity", {31'h0, ce_before > 0}, 32'h1);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
